// File: rtl/apb_cmd_sequencer.sv
// Queues host read/write commands and issues them one at a time to an APB master,
// returning a one-cycle response strobe with read data or a timeout error.
module apb_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_wdata_i,
  output logic [1:0]  add_o,
  output logic [31:0] wdata_o,
  input  logic        mst_ready_i,
  input  logic [31:0] mst_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [32:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_wait;
  logic [1:0]      r_add;
  logic [31:0]     r_wdata, r_rsp_rdata;
  logic            r_rsp_valid, r_rsp_err;

  logic            w_push, w_pop, w_ack, w_tmo;
  logic [32:0]     w_head;

  assign cmd_ready_o = (r_count < DEPTH_C);
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_mem[r_rptr];
  // Ready takes priority over the timeout when both land on the same cycle.
  assign w_ack       = (r_state == S_ACCESS) && mst_ready_i;
  assign w_tmo       = (r_state == S_ACCESS) && !mst_ready_i && (r_wait == TO_LAST);

  assign add_o       = r_add;
  assign wdata_o     = r_wdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_next = S_ACCESS;
      S_ACCESS: if (w_ack || w_tmo) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Storage carries no reset; occupancy is defined by the pointers and count.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_write_i, cmd_wdata_i};
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wait      <= '0;
      r_add       <= 2'b00;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      if (w_pop) begin
        r_add  <= w_head[32] ? 2'b11 : 2'b01;
        r_wait <= '0;
        if (w_head[32]) r_wdata <= w_head[31:0];
      end else if (w_ack) begin
        r_add       <= 2'b00;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (r_add == 2'b11) ? 32'h0 : mst_rdata_i;
      end else if (w_tmo) begin
        r_add       <= 2'b00;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end else if (r_state == S_ACCESS) begin
        r_wait <= r_wait + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Randomized and directed bench for apb_cmd_sequencer, checked every cycle against
// a transaction-level model (command queue + issued command age).
module tb_apb_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_write, mst_ready;
  logic [31:0] cmd_wdata, mst_rdata;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, busy_o;
  logic [1:0]  add_o;
  logic [31:0] wdata_o, rsp_rdata_o;

  int n_chk = 0, n_fail = 0, n_rsp = 0;

  apb_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write), .cmd_wdata_i(cmd_wdata),
    .add_o(add_o), .wdata_o(wdata_o),
    .mst_ready_i(mst_ready), .mst_rdata_i(mst_rdata),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 pclk = ~pclk;

  // Reference model: pending commands, the command in flight and how long it has waited.
  logic [32:0] m_q [$];
  logic [32:0] m_cur;
  int          m_phase;  // 0 idle, 1 command on the bus, 2 response cycle
  int          m_age;
  logic [1:0]  m_add;
  logic [31:0] m_wdata, m_rd;
  logic        m_rv, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0; m_age = 0; m_cur = '0;
    m_add = 2'b00; m_wdata = '0; m_rd = '0; m_rv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit accept;
    if (preset) return;
    accept = cmd_valid && (m_q.size() < DEPTH);
    m_rv = 1'b0; m_err = 1'b0;
    case (m_phase)
      0: if (m_q.size() > 0) begin
           m_cur = m_q.pop_front();
           m_add = m_cur[32] ? 2'b11 : 2'b01;
           if (m_cur[32]) m_wdata = m_cur[31:0];
           m_age = 0; m_phase = 1;
         end
      1: begin
           m_age++;
           if (mst_ready) begin
             m_rv = 1'b1; m_rd = m_cur[32] ? 32'h0 : mst_rdata;
             m_add = 2'b00; m_phase = 2;
           end else if (m_age == TIMEOUT) begin
             m_rv = 1'b1; m_err = 1'b1; m_rd = 32'h0;
             m_add = 2'b00; m_phase = 2;
           end
         end
      default: m_phase = 0;
    endcase
    if (accept) m_q.push_back({cmd_write, cmd_wdata});
  endtask

  task automatic check_all();
    chk("add_o", add_o, m_add);
    chk("wdata_o", wdata_o, m_wdata);
    chk("rsp_valid_o", rsp_valid_o, m_rv);
    chk("rsp_rdata_o", rsp_rdata_o, m_rd);
    chk("rsp_err_o", rsp_err_o, m_err);
    chk("cmd_ready_o", cmd_ready_o, (m_q.size() < DEPTH));
    chk("busy_o", busy_o, (m_phase != 0) || (m_q.size() > 0));
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    #1;
    check_all();
    if (rsp_valid_o) n_rsp++;
  endtask

  task automatic push(input bit w, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (busy_o && c < max) begin step(); c++; end
    chk("drain_idle", busy_o, 1'b0);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    model_reset();
    #1;
    check_all();
    step();
    preset = 1'b0;
  endtask

  initial begin
    int n, pr;
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_wdata = '0;
    mst_ready = 1'b0; mst_rdata = '0;
    model_reset();
    #1;
    check_all();
    step();
    preset = 1'b0;

    // Write with ready arriving three cycles into the access.
    push(1'b1, 32'h1234ABCD);
    step();
    chk("wr_add", add_o, 2'b11);
    chk("wr_wdata", wdata_o, 32'h1234ABCD);
    step(); step();
    mst_ready = 1'b1;
    n = n_rsp;
    step();
    chk("wr_rsp", n_rsp - n, 1);
    chk("wr_err", rsp_err_o, 1'b0);
    chk("wr_rdata", rsp_rdata_o, 32'h0);
    mst_ready = 1'b0;
    step();
    chk("wr_add_idle", add_o, 2'b00);
    drain(10);

    // Read returns the master data.
    mst_rdata = 32'h1234ABCD;
    push(1'b0, 32'hFFFF_FFFF);
    step();
    chk("rd_add", add_o, 2'b01);
    mst_ready = 1'b1;
    step();
    chk("rd_rdata", rsp_rdata_o, 32'h1234ABCD);
    chk("rd_err", rsp_err_o, 1'b0);
    mst_ready = 1'b0;
    drain(10);

    // Back-to-back pushes against a stalled master: five accepted, sixth dropped.
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_write = i[0]; cmd_wdata = 32'hA000_0000 + i;
      step();
    end
    cmd_valid = 1'b0;
    chk("full_ready", cmd_ready_o, 1'b0);
    n = n_rsp;
    mst_ready = 1'b1;
    for (int i = 0; i < 30 && busy_o; i++) begin
      mst_rdata = 32'hB000_0000 + i;
      step();
    end
    chk("full_nrsp", n_rsp - n, 5);
    mst_ready = 1'b0;
    drain(5);

    // Timeout: response exactly TIMEOUT cycles after the read is issued.
    push(1'b0, 32'h0);
    n = 0;
    while (add_o != 2'b01 && n < 5) begin step(); n++; end
    n = 0;
    while (!rsp_valid_o && n < 40) begin step(); n++; end
    chk("tmo_latency", n, TIMEOUT);
    chk("tmo_err", rsp_err_o, 1'b1);
    chk("tmo_rdata", rsp_rdata_o, 32'h0);
    push(1'b1, 32'h5555_AAAA);
    step(); step();
    chk("tmo_next_add", add_o, 2'b11);
    mst_ready = 1'b1;
    drain(10);
    mst_ready = 1'b0;

    // Ready arriving on the timeout cycle wins.
    mst_rdata = 32'hCAFEF00D;
    push(1'b0, 32'h0);
    step();
    chk("coin_add", add_o, 2'b01);
    repeat (TIMEOUT - 1) step();
    mst_ready = 1'b1;
    step();
    chk("coin_valid", rsp_valid_o, 1'b1);
    chk("coin_err", rsp_err_o, 1'b0);
    chk("coin_rdata", rsp_rdata_o, 32'hCAFEF00D);
    mst_ready = 1'b0;
    drain(10);

    // Reset in the middle of an access with two commands queued.
    cmd_valid = 1'b1; cmd_write = 1'b0;
    repeat (3) step();
    cmd_valid = 1'b0;
    step();
    chk("rst_pre_add", add_o, 2'b01);
    n = n_rsp;
    do_reset();
    repeat (3) step();
    chk("rst_no_rsp", n_rsp - n, 0);
    push(1'b1, 32'h0BAD_CAFE);
    step();
    chk("rst_new_add", add_o, 2'b11);
    mst_ready = 1'b1;
    drain(10);

    // Random traffic with phases of varying master responsiveness.
    pr = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) pr = $urandom_range(0, 6);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_write = $urandom_range(0, 1);
      cmd_wdata = $urandom;
      mst_ready = ($urandom_range(0, 9) < pr);
      mst_rdata = $urandom;
      step();
    end
    cmd_valid = 1'b0; mst_ready = 1'b1;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_cmd_sequencer.md
APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for mst_ready_i, 2..255.
REQ-003 pclk  input  1  single clock; all state updates on rising edge.
REQ-004 preset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid_i  input  1  host command valid.
REQ-006 cmd_ready_o  output  1  FIFO can accept a command.
REQ-007 cmd_write_i  input  1  1 = write, 0 = read.
REQ-008 cmd_wdata_i  input  32  write data; ignored for reads.
REQ-009 add_o  output  2  command to APB master add_i: 2'b11 write, 2'b01 read, 2'b00 idle.
REQ-010 wdata_o  output  32  to APB master external_wdata_i.
REQ-011 mst_ready_i  input  1  APB master ready_o.
REQ-012 mst_rdata_i  input  32  APB master rdata_o.
REQ-013 rsp_valid_o  output  1  one-cycle response strobe.
REQ-014 rsp_rdata_o  output  32  read data; 0 for writes and timeouts.
REQ-015 rsp_err_o  output  1  response terminated by timeout; valid with rsp_valid_o.
REQ-016 busy_o  output  1  high when state != IDLE or FIFO non-empty.

Function
REQ-017 Push SHALL occur on an edge where cmd_valid_i && cmd_ready_o; entry = {cmd_write_i, cmd_wdata_i}.
REQ-018 cmd_ready_o SHALL be (count < DEPTH), combinational from count only; a pop in the same cycle does not enable a push when full.
REQ-019 A valid offered while full SHALL be ignored; FIFO contents and count unchanged.
REQ-020 FIFO SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH; count width SHALL be clog2(DEPTH)+1.
REQ-021 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-022 IDLE: if FIFO non-empty, pop the head at the edge, register add_o (11/01) and wdata_o (write data, else unchanged), clear wait counter, go to ACCESS; else stay, add_o = 00.
REQ-023 Push at edge N into an empty FIFO in IDLE SHALL produce non-zero add_o after edge N+1.
REQ-024 ACCESS: add_o and wdata_o SHALL be held stable; wait counter SHALL increment by 1 per cycle.
REQ-025 ACCESS, mst_ready_i sampled high at edge M: add_o <= 00, rsp_valid_o <= 1, rsp_err_o <= 0, rsp_rdata_o <= mst_rdata_i (read) or 0 (write), go to DONE.
REQ-026 ACCESS, counter == TIMEOUT-1 with mst_ready_i low: add_o <= 00, rsp_valid_o <= 1, rsp_err_o <= 1, rsp_rdata_o <= 0, go to DONE.
REQ-027 If mst_ready_i and timeout coincide, ready SHALL win (rsp_err_o = 0).
REQ-028 DONE: rsp_valid_o and rsp_err_o SHALL deassert at the next edge; go to IDLE; exactly one cycle in DONE, so add_o is 00 for at least two cycles between commands.
REQ-029 rsp_rdata_o SHALL hold its value until the next response.
REQ-030 Pushes SHALL be accepted in every state.
REQ-031 mst_ready_i SHALL be ignored outside ACCESS.

Reset
REQ-032 preset high SHALL immediately force: state IDLE, FIFO empty (pointers, count 0), wait counter 0, add_o 00, wdata_o 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0; hence cmd_ready_o 1, busy_o 0.
REQ-033 Reset asserted mid-ACCESS SHALL abandon the command with no response; queued commands are discarded.
REQ-034 After preset falls, first push SHALL be accepted at the next rising edge.

Verification
REQ-035 Write 0x1234ABCD, mst_ready_i high 3 cycles after add_o=11 -> wdata_o=0x1234ABCD during ACCESS; one rsp_valid_o pulse, rsp_err_o 0, rsp_rdata_o 0; add_o returns 00.
REQ-036 Read with mst_rdata_i=0x1234ABCD at ready -> add_o=01, rsp_rdata_o=0x1234ABCD, rsp_err_o 0.
REQ-037 Push 5 commands back-to-back with mst_ready_i low, DEPTH=4 -> first pops to ACCESS, next 4 fill FIFO, cmd_ready_o low, 6th valid ignored; release ready -> 5 responses in push order.
REQ-038 Read with mst_ready_i never high, TIMEOUT=16 -> rsp_valid_o and rsp_err_o high exactly 16 cycles after add_o=01, rsp_rdata_o 0, next command issues.
REQ-039 mst_ready_i rising on the timeout cycle -> rsp_err_o 0, data captured.
REQ-040 preset asserted during ACCESS with 2 queued -> all outputs at reset values, no rsp_valid_o; new command after release executes normally.
